// File: rtl/maddr_pkg.sv
// rtl/maddr_pkg.sv - shared types, defaults and field helper for maddr_gen
package maddr_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int AW_DEFAULT = 10;
   localparam int MW_DEFAULT = 4;

   // A field value of 0 encodes the full range 2^mw
   function automatic int unsigned eff_val(input int unsigned field, input int unsigned mw);
      return (field == 0) ? (32'd1 << mw) : field;
   endfunction

endpackage

// File: rtl/maddr_step.sv
// rtl/maddr_step.sv - next matrix address: addr + stride, wrapping at 2^AW
module maddr_step
   import maddr_pkg::*;
#(
   parameter int AW = AW_DEFAULT,
   parameter int MW = MW_DEFAULT
) (
   input  logic [AW-1:0] addr,
   input  logic [MW:0]   stride,
   output logic [AW-1:0] next
);

   // Sum is truncated to AW bits so the address space wraps silently
   assign next = addr + AW'(stride);

endmodule

// File: rtl/maddr_gen.sv
// rtl/maddr_gen.sv - matrix vector address generator; optional MADDR_COLWRAP_EN column advance
module maddr_gen
   import maddr_pkg::*;
#(
   parameter int AW = AW_DEFAULT,
   parameter int MW = MW_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld,
   input  logic [AW+1:0] din,
   input  logic          mode,
   input  logic [MW-1:0] mwidth,
   input  logic [MW-1:0] len,
   input  logic          en,
   output logic [AW-1:0] maddr,
   output logic          busy,
   output logic          last,
   output logic          done
);

   localparam logic [MW:0] CNT_ONE = (MW+1)'(1);

   state_t        state, state_nxt;
   logic [MW:0]   cnt;
   logic [MW:0]   stride_q;
   logic [MW:0]   len_q;
   logic [MW:0]   len_e;
   logic [MW:0]   stride_e;
   logic [AW-1:0] maddr_nxt;
   logic          is_last;
   logic          din_unused;

   // Byte-offset bits of the bus carry no address information
   assign din_unused = ^din[1:0];

   assign len_e    = (MW+1)'(eff_val(32'(len), MW));
   assign stride_e = mode ? (MW+1)'(eff_val(32'(mwidth), MW)) : CNT_ONE;
   assign is_last  = (cnt == len_q - CNT_ONE);

   maddr_step #(.AW(AW), .MW(MW)) u_step (
      .addr   (maddr),
      .stride (stride_q),
      .next   (maddr_nxt)
   );

`ifdef MADDR_COLWRAP_EN
   localparam logic [AW-1:0] ADDR_ONE = AW'(1);
   logic          mode_q;
   logic [AW-1:0] vbase;
   logic          restart_ok;

   // A restart from IDLE only makes sense once a configuration has been loaded
   assign restart_ok = (len_q != '0);
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state: load always starts a vector, final element returns to idle
   always_comb begin
      state_nxt = state;
      if (ld)
         state_nxt = RUN;
      else if (state == RUN && en && is_last)
         state_nxt = IDLE;
`ifdef MADDR_COLWRAP_EN
      else if (state == IDLE && en && restart_ok)
         state_nxt = RUN;
`endif
   end

   // Outputs decoded from registers so last has no latency
   always_comb begin
      busy = (state == RUN);
      last = (state == RUN) && is_last;
   end

   // Address, counter, latched configuration and done pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         maddr    <= '0;
         cnt      <= '0;
         stride_q <= '0;
         len_q    <= '0;
         done     <= 1'b0;
`ifdef MADDR_COLWRAP_EN
         mode_q   <= 1'b0;
         vbase    <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (ld) begin
            maddr    <= din[AW+1:2];
            cnt      <= '0;
            stride_q <= stride_e;
            len_q    <= len_e;
`ifdef MADDR_COLWRAP_EN
            mode_q   <= mode;
            vbase    <= din[AW+1:2];
`endif
         end else if (state == RUN && en) begin
            if (is_last) begin
               done <= 1'b1;
`ifdef MADDR_COLWRAP_EN
               if (mode_q) begin
                  maddr <= vbase + ADDR_ONE;
                  vbase <= vbase + ADDR_ONE;
               end
`endif
            end else begin
               maddr <= maddr_nxt;
               cnt   <= cnt + CNT_ONE;
            end
         end
`ifdef MADDR_COLWRAP_EN
         else if (state == IDLE && en && restart_ok) begin
            cnt <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_maddr_gen.sv
// tb/tb_maddr_gen.sv - self-checking bench for maddr_gen with expected-value scoreboard
module tb_maddr_gen;

   localparam int AW = 10;
   localparam int MW = 4;

   logic          clk;
   logic          reset;
   logic          ld;
   logic [AW+1:0] din;
   logic          mode;
   logic [MW-1:0] mwidth;
   logic [MW-1:0] len;
   logic          en;
   logic [AW-1:0] maddr;
   logic          busy;
   logic          last;
   logic          done;

   typedef struct {
      string         tag;
      logic [AW-1:0] a;
      logic          b;
      logic          l;
      logic          d;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   maddr_gen #(.AW(AW), .MW(MW)) dut (
      .clk    (clk),
      .reset  (reset),
      .ld     (ld),
      .din    (din),
      .mode   (mode),
      .mwidth (mwidth),
      .len    (len),
      .en     (en),
      .maddr  (maddr),
      .busy   (busy),
      .last   (last),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [AW-1:0] a, input logic b, input logic l, input logic d);
      exp_t e;
      e.tag = tag; e.a = a; e.b = b; e.l = l; e.d = d;
      sb.push_back(e);
   endtask

   task automatic check();
      exp_t e;
      e = sb.pop_front();
      checks++;
      assert (maddr === e.a) else begin
         errors++;
         $error("FAIL %s maddr got %h exp %h", e.tag, maddr, e.a);
      end
      checks++;
      assert (busy === e.b) else begin
         errors++;
         $error("FAIL %s busy got %b exp %b", e.tag, busy, e.b);
      end
      checks++;
      assert (last === e.l) else begin
         errors++;
         $error("FAIL %s last got %b exp %b", e.tag, last, e.l);
      end
      checks++;
      assert (done === e.d) else begin
         errors++;
         $error("FAIL %s done got %b exp %b", e.tag, done, e.d);
      end
   endtask

   // Inputs are set at a falling edge; one rising edge later the outputs are sampled
   task automatic step(input string tag, input logic [AW-1:0] a, input logic b, input logic l, input logic d);
      push(tag, a, b, l, d);
      @(posedge clk);
      @(negedge clk);
      check();
   endtask

   task automatic load(input logic [AW-1:0] base, input logic m, input logic [MW-1:0] w, input logic [MW-1:0] n);
      ld = 1'b1; din = {base, 2'b11}; mode = m; mwidth = w; len = n;
   endtask

   initial begin
      logic [AW-1:0] wa;
      reset = 1'b1; ld = 1'b0; din = '0; mode = 1'b0; mwidth = '0; len = '0; en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      push("reset", '0, 1'b0, 1'b0, 1'b0);
      check();
      reset = 1'b0;

      // Row walk, base 0x010, four elements
      load(10'h010, 1'b0, 4'd0, 4'd4);
      step("row_ld", 10'h010, 1'b1, 1'b0, 1'b0);
      ld = 1'b0; en = 1'b1;
      step("row_e1", 10'h011, 1'b1, 1'b0, 1'b0);
      step("row_e2", 10'h012, 1'b1, 1'b0, 1'b0);
      step("row_e3", 10'h013, 1'b1, 1'b1, 1'b0);
      step("row_end", 10'h013, 1'b0, 1'b0, 1'b1);
      en = 1'b0;
      step("row_hold", 10'h013, 1'b0, 1'b0, 1'b0);

      // Column walk, base 0x020, stride 3, three elements
      load(10'h020, 1'b1, 4'd3, 4'd3);
      step("col_ld", 10'h020, 1'b1, 1'b0, 1'b0);
      ld = 1'b0; en = 1'b1;
      step("col_e1", 10'h023, 1'b1, 1'b0, 1'b0);
      step("col_e2", 10'h026, 1'b1, 1'b1, 1'b0);
`ifdef MADDR_COLWRAP_EN
      step("col_end", 10'h021, 1'b0, 1'b0, 1'b1);
`else
      step("col_end", 10'h026, 1'b0, 1'b0, 1'b1);
`endif
      en = 1'b0;
`ifdef MADDR_COLWRAP_EN
      step("col_hold", 10'h021, 1'b0, 1'b0, 1'b0);
`else
      step("col_hold", 10'h026, 1'b0, 1'b0, 1'b0);
`endif

      // Address wrap with zero fields: stride 16, sixteen elements
      load(10'h3FE, 1'b1, 4'd0, 4'd0);
      step("wrap_ld", 10'h3FE, 1'b1, 1'b0, 1'b0);
      ld = 1'b0; en = 1'b1;
      wa = 10'h3FE;
      for (int k = 1; k <= 15; k++) begin
         wa = wa + 10'd16;
         step("wrap_step", wa, 1'b1, (k == 15), 1'b0);
      end
`ifdef MADDR_COLWRAP_EN
      step("wrap_end", 10'h3FF, 1'b0, 1'b0, 1'b1);
`else
      step("wrap_end", wa, 1'b0, 1'b0, 1'b1);
`endif
      en = 1'b0;

      // ld and en together: load wins, no step
      load(10'h100, 1'b0, 4'd0, 4'd4);
      step("col_ld2", 10'h100, 1'b1, 1'b0, 1'b0);
      ld = 1'b0; en = 1'b1;
      step("col_e", 10'h101, 1'b1, 1'b0, 1'b0);
      load(10'h080, 1'b0, 4'd0, 4'd2);
      step("ld_en", 10'h080, 1'b1, 1'b0, 1'b0);
      ld = 1'b0;
      step("ld_en_e1", 10'h081, 1'b1, 1'b1, 1'b0);
      // ld on the final element abandons the vector without done
      load(10'h0C0, 1'b0, 4'd0, 4'd3);
      step("ld_last", 10'h0C0, 1'b1, 1'b0, 1'b0);
      ld = 1'b0; en = 1'b0;
      step("ld_last_hold", 10'h0C0, 1'b1, 1'b0, 1'b0);

      // Async reset after three steps
      load(10'h010, 1'b0, 4'd0, 4'd8);
      step("rst_ld", 10'h010, 1'b1, 1'b0, 1'b0);
      ld = 1'b0; en = 1'b1;
      step("rst_e1", 10'h011, 1'b1, 1'b0, 1'b0);
      step("rst_e2", 10'h012, 1'b1, 1'b0, 1'b0);
      step("rst_e3", 10'h013, 1'b1, 1'b0, 1'b0);
      en = 1'b0;
      reset = 1'b1;
      #1;
      push("rst_async", '0, 1'b0, 1'b0, 1'b0);
      check();
      @(negedge clk);
      reset = 1'b0;

      // Single-element vector, then en while idle
      load(10'h055, 1'b0, 4'd0, 4'd1);
      step("one_ld", 10'h055, 1'b1, 1'b1, 1'b0);
      ld = 1'b0; en = 1'b1;
      step("one_end", 10'h055, 1'b0, 1'b0, 1'b1);
`ifndef MADDR_COLWRAP_EN
      step("idle_en1", 10'h055, 1'b0, 1'b0, 1'b0);
      step("idle_en2", 10'h055, 1'b0, 1'b0, 1'b0);
`endif
      en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/maddr_gen.md
Name: maddr_gen

Overview:
- Parametrised matrix-address generator for the GPU systolic MMULT path; successor to the fixed 10-bit matrix address counter.
- Loads a word-aligned base from the GPU data bus, then walks one matrix vector of programmable length.
- Row mode steps by 1; column mode steps by the matrix width.
- Tracks element count, flags the last element and pulses done at vector end.

Parameters:
AW, 10, address width in words; bus base is AW+2 bits with bits [1:0] ignored.
MW, 4, width of the mwidth and len fields; field value 0 means 2^MW.

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
ld  in  1  load base and configuration, start a vector
din  in  AW+2  GPU data bus; din[AW+1:2] is the base word address
mode  in  1  0 = row (step 1), 1 = column (step mwidth); sampled at ld
mwidth  in  MW  matrix width (column stride); sampled at ld
len  in  MW  elements per vector; sampled at ld
en  in  1  advance one element
maddr  out  AW  current matrix word address
busy  out  1  vector in progress
last  out  1  current element is the final one of the vector
done  out  1  one-cycle pulse after the final element is consumed

Behaviour:
- Reset (async, active-high):
  - maddr=0, busy=0, done=0, last=0.
  - Element count cnt=0.
  - Latched mode, stride, length and vector base cleared; state IDLE.
- Effective values: len_e = (len==0) ? 2^MW : len; stride = mode ? ((mwidth==0) ? 2^MW : mwidth) : 1.
- States are IDLE and RUN; busy = (state==RUN).
- ld, any state:
  - maddr <= din[AW+1:2]; vbase <= same value.
  - cnt <= 0; latch mode, stride and len_e; state <= RUN; done <= 0.
  - ld has priority over en in the same cycle.
  - ld during RUN abandons the current vector; no done pulse is produced.
- en in RUN with cnt != len_e-1:
  - maddr <= maddr + stride, modulo 2^AW (silent wrap).
  - cnt <= cnt+1.
- en in RUN with cnt == len_e-1:
  - done <= 1 for exactly one cycle; state <= IDLE.
  - maddr holds the last address (no step).
- en in IDLE: ignored unless the optional feature is enabled.
- en=0: all state holds; done clears after one cycle regardless.
- last = busy & (cnt == len_e-1); combinational from registers, so zero-latency.
- Latency: maddr updates the cycle after an accepted ld or en.
- Configuration inputs are ignored outside the ld cycle.
- cnt width is MW+1 so that len_e = 2^MW is representable.

Optional Feature:
- Macro: MADDR_COLWRAP_EN.
- With the macro defined, end of vector in column mode does two things:
  - maddr <= vbase+1 and vbase <= vbase+1, modulo 2^AW; state <= IDLE; done pulses as normal.
  - The next en in IDLE restarts RUN from the current maddr with cnt=0, reusing the latched configuration, so successive columns need no reload.
- End of vector in row mode behaves as without the macro.
- Without the macro: no column advance, and en in IDLE is ignored.

Decomposition:
- Package maddr_pkg holds:
  - state enum {IDLE, RUN};
  - default AW/MW constants;
  - an effective-value helper function mapping a field value of 0 to 2^MW.
- Sub-module maddr_step (combinational next-address adder: maddr + stride with wrap) is natural. Keep the FSM and counter in maddr_gen.

Test Plan:
- Reset mid-RUN (after 3 steps) -> maddr=0, busy=0, last=0, done=0 immediately, asynchronously.
- Row walk: ld with din=0x040 (base 0x010), mode=0, len=4, then en x4 -> maddr 0x010,0x011,0x012,0x013; last high only at 0x013; done pulses one cycle after the 4th en; maddr holds 0x013.
- Column walk: base 0x020, mode=1, mwidth=3, len=3, en x3 -> maddr 0x020,0x023,0x026; done once. With MADDR_COLWRAP_EN: maddr becomes 0x021, then a further en x3 -> 0x021,0x024,0x027.
- Wrap and zero fields: base 0x3FE, mode=1, mwidth=0 (stride 16), len=0 (16 elements) -> second address 0x00E; done only after the 16th en.
- Collisions: ld and en in the same cycle -> load wins, cnt=0, no step. ld on the last element -> no done pulse, new base loaded.
- en in IDLE without the macro -> maddr, busy and done unchanged.
